pc_fetch_unit: RTL and testbench

//  Holds the program counter and computes the next fetch address.

---
 rtl/cpu_pkg.sv | 31 +++
 rtl/branch_target_calc.sv | 35 +++
 rtl/pc_fetch_unit.sv | 106 ++++++++++
 tb/tb_pc_fetch_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Package     : cpu_pkg
// Description : Shared types and default constants for the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    typedef enum logic [1:0] {
        NONE   = 2'b00,
        BRANCH = 2'b01,
        JAL    = 2'b10,
        JALR   = 2'b11
    } tipo_salto_t;

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_FETCH = 2'd1,
        S_REDIR = 2'd2
    } fetch_state_t;

    localparam logic [31:0] c_default_reset_pc = 32'h0000_0000;
    localparam logic [31:0] c_default_trap_vec = 32'h0000_0100;

    // A jump type plus comparator result says whether EX wants a redirect.
    function automatic logic is_redirect(input logic [1:0] tipo, input logic taken);
        return (tipo == JAL) || (tipo == JALR) || ((tipo == BRANCH) && taken);
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_target_calc.sv
`default_nettype none
// ============================================================================
// Module      : branch_target_calc
// Description : Combinational redirect target and misalignment detection.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_target_calc
    import cpu_pkg::*;
(
    input  logic [1:0]  tipo_salto,
    input  logic [31:0] pc_ex,
    input  logic [31:0] imm,
    input  logic [31:0] valA,
    output logic [31:0] target,
    output logic        misaligned
);

    logic [31:0] w_pc_rel;
    logic [31:0] w_reg_rel;

    assign w_pc_rel  = pc_ex + imm;
    // jalr drops bit 0, so only bit 1 can make its target misaligned
    assign w_reg_rel = (valA + imm) & ~32'h1;

    always_comb begin
        target     = w_pc_rel;
        misaligned = |w_pc_rel[1:0];
        if (tipo_salto == JALR) begin
            target     = w_reg_rel;
            misaligned = w_reg_rel[1];
        end
    end

endmodule
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_unit
// Description : Program counter, fetch request FSM and redirect/trap handling.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_default_reset_pc,
    parameter logic [31:0] TRAP_VEC = c_default_trap_vec
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic [1:0]  tipo_salto,
    input  logic        resultado,
    input  logic [31:0] pc_ex,
    input  logic [31:0] imm,
    input  logic [31:0] valA,
    input  logic        imem_ready,
    output logic [31:0] pc,
    output logic [31:0] pc_mas4,
    output logic        imem_valid,
    output logic        flush,
    output logic        excep_desal,
    output logic [31:0] cnt_saltos
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic [31:0]  r_pc;
    logic         r_flush;
    logic         r_excep;
    logic [31:0]  r_cnt;
    logic [31:0]  w_target;
    logic         w_misaligned;
    logic         w_redirect;
    logic         w_advance;

    branch_target_calc u_target (
        .tipo_salto (tipo_salto),
        .pc_ex      (pc_ex),
        .imm        (imm),
        .valA       (valA),
        .target     (w_target),
        .misaligned (w_misaligned)
    );

    // EX only carries a bubble outside S_FETCH, so redirects are ignored there.
    assign w_redirect = (r_state == S_FETCH) && is_redirect(tipo_salto, resultado);
    assign w_advance  = (r_state == S_FETCH) && !w_redirect && !stall && imem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_INIT:  w_state_nxt = S_FETCH;
            S_FETCH: if (w_redirect) w_state_nxt = S_REDIR;
            S_REDIR: w_state_nxt = S_FETCH;
            default: w_state_nxt = S_INIT;
        endcase
    end

    always_comb begin
        imem_valid = 1'b0;
        if (r_state == S_FETCH) begin
            imem_valid = !stall;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= RESET_PC;
            r_flush <= 1'b0;
            r_excep <= 1'b0;
            r_cnt   <= 32'h0;
        end else begin
            r_flush <= w_redirect;
            r_excep <= w_redirect && w_misaligned;
            if (w_redirect) begin
                r_pc <= w_misaligned ? TRAP_VEC : w_target;
                if (r_cnt != 32'hFFFF_FFFF) begin
                    r_cnt <= r_cnt + 32'd1;
                end
            end else if (w_advance) begin
                r_pc <= r_pc + 32'd4;
            end
        end
    end

    assign pc          = r_pc;
    assign pc_mas4     = r_pc + 32'd4;
    assign flush       = r_flush;
    assign excep_desal = r_excep;
    assign cnt_saltos  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_fetch_unit
// Description : Self-checking bench: directed vector table, async reset
//               sequence and randomized traffic against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_unit;

    localparam logic [31:0] c_reset_pc = 32'h0000_0000;
    localparam logic [31:0] c_trap_vec = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic [1:0]  tipo_salto;
    logic        resultado;
    logic [31:0] pc_ex;
    logic [31:0] imm;
    logic [31:0] valA;
    logic        imem_ready;
    logic [31:0] pc;
    logic [31:0] pc_mas4;
    logic        imem_valid;
    logic        flush;
    logic        excep_desal;
    logic [31:0] cnt_saltos;

    int n_tests = 0;
    int n_fail  = 0;

    pc_fetch_unit #(
        .RESET_PC (c_reset_pc),
        .TRAP_VEC (c_trap_vec)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .tipo_salto  (tipo_salto),
        .resultado   (resultado),
        .pc_ex       (pc_ex),
        .imm         (imm),
        .valA        (valA),
        .imem_ready  (imem_ready),
        .pc          (pc),
        .pc_mas4     (pc_mas4),
        .imem_valid  (imem_valid),
        .flush       (flush),
        .excep_desal (excep_desal),
        .cnt_saltos  (cnt_saltos)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic [1:0]  tipo;
        logic        res;
        logic [31:0] pe;
        logic [31:0] im;
        logic [31:0] va;
        logic        rdy;
        logic        e_valid;
        logic [31:0] e_pc;
        logic        e_flush;
        logic        e_exc;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t tbl[32];

    function automatic vec_t v(input logic st, input logic [1:0] tipo, input logic res,
                               input logic [31:0] pe, input logic [31:0] im,
                               input logic [31:0] va, input logic rdy,
                               input logic ev, input logic [31:0] epc,
                               input logic ef, input logic ee, input logic [31:0] ec);
        vec_t r;
        r.st = st; r.tipo = tipo; r.res = res; r.pe = pe; r.im = im; r.va = va;
        r.rdy = rdy; r.e_valid = ev; r.e_pc = epc; r.e_flush = ef; r.e_exc = ee;
        r.e_cnt = ec;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic [1:0] tipo, input logic res,
                         input logic [31:0] pe, input logic [31:0] im,
                         input logic [31:0] va, input logic rdy);
        stall = st; tipo_salto = tipo; resultado = res;
        pc_ex = pe; imm = im; valA = va; imem_ready = rdy;
    endtask

    // Reference model: fetch slot availability, PC and redirect bookkeeping.
    logic [31:0] m_pc;
    logic        m_slot;
    logic        m_flush;
    logic        m_exc;
    logic [31:0] m_cnt;

    task automatic model_reset();
        m_pc = c_reset_pc; m_slot = 1'b0; m_flush = 1'b0; m_exc = 1'b0; m_cnt = 32'h0;
    endtask

    task automatic model_edge();
        longint unsigned t;
        bit wants;
        bit mis;
        wants = (tipo_salto == 2'b10) || (tipo_salto == 2'b11) ||
                (tipo_salto == 2'b01 && resultado);
        if (m_slot && wants) begin
            if (tipo_salto == 2'b11) begin
                t = (64'(valA) + 64'(imm)) % 64'h1_0000_0000;
                t = t - (t % 2);
            end else begin
                t = (64'(pc_ex) + 64'(imm)) % 64'h1_0000_0000;
            end
            mis     = (t % 4) != 0;
            m_pc    = mis ? c_trap_vec : 32'(t);
            m_flush = 1'b1;
            m_exc   = mis;
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            m_slot  = 1'b0;
        end else begin
            m_flush = 1'b0;
            m_exc   = 1'b0;
            if (m_slot && !stall && imem_ready)
                m_pc = 32'((64'(m_pc) + 64'd4) % 64'h1_0000_0000);
            m_slot  = 1'b1;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] r32;
        logic [31:0] ex_pc4;

        tbl[0]  = v(0, 2'd2, 0, 32'h10, 32'h20, 0, 1,          0, 32'h0, 0, 0, 0);
        tbl[1]  = v(0, 2'd0, 0, 0, 0, 0, 1,                    1, 32'h4, 0, 0, 0);
        tbl[2]  = v(0, 2'd0, 0, 0, 0, 0, 1,                    1, 32'h8, 0, 0, 0);
        tbl[3]  = v(0, 2'd0, 0, 0, 0, 0, 1,                    1, 32'hC, 0, 0, 0);
        tbl[4]  = v(0, 2'd1, 1, 32'h40, 32'hFFFF_FFF0, 0, 1,   1, 32'h30, 1, 0, 1);
        tbl[5]  = v(0, 2'd2, 0, 32'h10, 32'h20, 0, 1,          0, 32'h30, 0, 0, 1);
        tbl[6]  = v(0, 2'd0, 0, 0, 0, 0, 1,                    1, 32'h34, 0, 0, 1);
        tbl[7]  = v(0, 2'd1, 0, 0, 32'h8, 0, 1,                1, 32'h38, 0, 0, 1);
        tbl[8]  = v(0, 2'd3, 0, 0, 0, 32'h103, 1,              1, 32'h100, 1, 1, 2);
        tbl[9]  = v(0, 2'd0, 0, 0, 0, 0, 1,                    0, 32'h100, 0, 0, 2);
        tbl[10] = v(1, 2'd2, 0, 32'h10, 32'h20, 0, 1,          0, 32'h30, 1, 0, 3);
        tbl[11] = v(0, 2'd0, 0, 0, 0, 0, 1,                    0, 32'h30, 0, 0, 3);
        tbl[12] = v(1, 2'd0, 0, 0, 0, 0, 1,                    0, 32'h30, 0, 0, 3);
        tbl[13] = v(0, 2'd0, 0, 0, 0, 0, 0,                    1, 32'h30, 0, 0, 3);
        tbl[14] = v(0, 2'd0, 0, 0, 0, 0, 0,                    1, 32'h30, 0, 0, 3);
        tbl[15] = v(0, 2'd0, 0, 0, 0, 0, 0,                    1, 32'h30, 0, 0, 3);
        tbl[16] = v(0, 2'd0, 0, 0, 0, 0, 1,                    1, 32'h34, 0, 0, 3);
        tbl[17] = v(0, 2'd2, 0, 32'h100, 32'h2, 0, 1,          1, 32'h100, 1, 1, 4);
        tbl[18] = v(0, 2'd0, 0, 0, 0, 0, 1,                    0, 32'h100, 0, 0, 4);
        tbl[19] = v(0, 2'd1, 1, 32'h200, 32'h1, 0, 1,          1, 32'h100, 1, 1, 5);
        tbl[20] = v(0, 2'd0, 0, 0, 0, 0, 1,                    0, 32'h100, 0, 0, 5);
        tbl[21] = v(0, 2'd3, 0, 0, 32'h3, 32'h201, 0,          1, 32'h204, 1, 0, 6);
        tbl[22] = v(0, 2'd0, 0, 0, 0, 0, 1,                    0, 32'h204, 0, 0, 6);
        tbl[23] = v(0, 2'd3, 0, 0, 0, 32'h1, 1,                1, 32'h0, 1, 0, 7);
        tbl[24] = v(0, 2'd0, 0, 0, 0, 0, 1,                    0, 32'h0, 0, 0, 7);
        tbl[25] = v(0, 2'd0, 1, 0, 0, 0, 1,                    1, 32'h4, 0, 0, 7);
        tbl[26] = v(0, 2'd2, 0, 32'hFFFF_FFF0, 32'hC, 0, 1,    1, 32'hFFFF_FFFC, 1, 0, 8);
        tbl[27] = v(0, 2'd0, 0, 0, 0, 0, 1,                    0, 32'hFFFF_FFFC, 0, 0, 8);
        tbl[28] = v(0, 2'd0, 0, 0, 0, 0, 1,                    1, 32'h0, 0, 0, 8);
        tbl[29] = v(0, 2'd2, 0, 32'hFFFF_FFF0, 32'h14, 0, 1,   1, 32'h4, 1, 0, 9);
        tbl[30] = v(0, 2'd0, 0, 0, 0, 0, 1,                    0, 32'h4, 0, 0, 9);
        tbl[31] = v(0, 2'd0, 0, 0, 0, 0, 1,                    1, 32'h8, 0, 0, 9);

        // Reset state
        rst_n = 1'b0;
        drive(0, 2'd0, 0, 0, 0, 0, 1);
        repeat (2) @(posedge clk);
        #1;
        chk("reset pc", pc, c_reset_pc);
        chk("reset flush", 32'(flush), 0);
        chk("reset excep", 32'(excep_desal), 0);
        chk("reset cnt", cnt_saltos, 0);
        chk("reset valid", 32'(imem_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vector table, first row lands in the post-reset init cycle
        for (int i = 0; i < 32; i++) begin
            drive(tbl[i].st, tbl[i].tipo, tbl[i].res, tbl[i].pe, tbl[i].im, tbl[i].va, tbl[i].rdy);
            #1;
            chk($sformatf("vec%0d valid", i), 32'(imem_valid), 32'(tbl[i].e_valid));
            @(posedge clk);
            #1;
            ex_pc4 = tbl[i].e_pc + 32'd4;
            chk($sformatf("vec%0d pc", i), pc, tbl[i].e_pc);
            chk($sformatf("vec%0d pc_mas4", i), pc_mas4, ex_pc4);
            chk($sformatf("vec%0d flush", i), 32'(flush), 32'(tbl[i].e_flush));
            chk($sformatf("vec%0d excep", i), 32'(excep_desal), 32'(tbl[i].e_exc));
            chk($sformatf("vec%0d cnt", i), cnt_saltos, tbl[i].e_cnt);
        end

        // Asynchronous reset while the redirect bubble is in progress
        drive(0, 2'd2, 0, 32'h80, 32'h10, 0, 1);
        @(posedge clk);
        #1;
        chk("redir pc", pc, 32'h90);
        chk("redir flush", 32'(flush), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst pc", pc, c_reset_pc);
        chk("async rst flush", 32'(flush), 0);
        chk("async rst cnt", cnt_saltos, 0);
        chk("async rst valid", 32'(imem_valid), 0);
        drive(0, 2'd0, 0, 0, 0, 0, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic against the reference model
        model_reset();
        for (int c = 0; c < 1500; c++) begin
            r32 = $urandom();
            stall      = ($urandom_range(0, 4) == 0);
            tipo_salto = 2'($urandom_range(0, 3));
            resultado  = 1'($urandom_range(0, 1));
            pc_ex      = {r32[31:2], 2'b00};
            imm        = 32'($urandom_range(0, 1023)) - 32'd512;
            if ($urandom_range(0, 1) == 0) imm = imm & ~32'h3;
            valA       = $urandom();
            imem_ready = ($urandom_range(0, 9) < 7);
            #1;
            chk($sformatf("rnd%0d valid", c), 32'(imem_valid), 32'(m_slot && !stall));
            @(posedge clk);
            model_edge();
            #1;
            chk($sformatf("rnd%0d pc", c), pc, m_pc);
            chk($sformatf("rnd%0d flush", c), 32'(flush), 32'(m_flush));
            chk($sformatf("rnd%0d excep", c), 32'(excep_desal), 32'(m_exc));
            chk($sformatf("rnd%0d cnt", c), cnt_saltos, m_cnt);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
